// File: rtl/intr_dispatcher_pkg.sv
// Shared constants for the interrupt dispatcher and its CP0 neighbours.
// Latency: n/a (constants only).
// Backpressure: n/a.
package intr_dispatcher_pkg;

  // Number of external IRQ lines; also the width of CP0 status[11:8].
  localparam int NUM_IRQ        = 4;
  localparam int IRQ_ID_W       = $clog2(NUM_IRQ);

  // Word-address width of the instruction memory (PC / EPC).
  localparam int IM_ADDR_BIT    = 12;

  // Handler vector layout, in words: line k lives at BASE + k*STRIDE.
  localparam int HANDLER_BASE   = 'h300;
  localparam int HANDLER_STRIDE = 'h40;

  // CP0 register numbers touched by interrupt entry and return.
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

endpackage

// File: rtl/intr_dispatcher_if.sv
// Pipeline/CP0-facing bundle of the interrupt dispatcher.
// Latency: wires only; master drives the entry strobe, slave drives the gating inputs.
// Backpressure: take_ok is the only stall input; no valid/ready pairs.
interface intr_dispatcher_if
  import intr_dispatcher_pkg::*;
#(
  parameter int NUM_IRQ = intr_dispatcher_pkg::NUM_IRQ,
  parameter int ADDR_W  = intr_dispatcher_pkg::IM_ADDR_BIT
);

  // Gating from CP0 and the pipeline
  logic                intr_en;
  logic [NUM_IRQ-1:0]  intr_mask;
  logic                take_ok;
  logic [ADDR_W-1:0]   pc_cur;
  logic                is_eret;

  // Interrupt entry towards CP0 and the fetch stage
  logic                epc_w_en;
  logic [ADDR_W-1:0]   epc_w_data;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_addr;
  logic [IRQ_ID_W-1:0] irq_id;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  in_service;

  // Dispatcher side
  modport master (
    input  intr_en, intr_mask, take_ok, pc_cur, is_eret,
    output epc_w_en, epc_w_data, redirect, redirect_addr, irq_id, pending, in_service
  );

  // CP0 / pipeline side
  modport slave (
    output intr_en, intr_mask, take_ok, pc_cur, is_eret,
    input  epc_w_en, epc_w_data, redirect, redirect_addr, irq_id, pending, in_service
  );

endinterface

// File: rtl/intr_dispatcher_irq_sync_edge.sv
// Two-flop synchroniser for one async IRQ level plus a one-cycle rising-edge pulse.
// Latency: rise is high in the cycle after the second edge that sees the level high.
// Backpressure: none; the pulse is fire-and-forget and must be latched by the caller.
module intr_dispatcher_irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Metastability chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= irq_raw;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/intr_dispatcher.sv
// Interrupt-entry initiator: latches IRQ edges, picks the best allowed line, issues EPC write + redirect.
// Latency: raw rise to pending is 3 edges; entry strobe is combinational from pending/in_service.
// Backpressure: take_ok=0 or eret holds every request in pending indefinitely.
module intr_dispatcher
  import intr_dispatcher_pkg::*;
#(
  parameter int NUM_IRQ        = intr_dispatcher_pkg::NUM_IRQ,
  parameter int ADDR_W         = intr_dispatcher_pkg::IM_ADDR_BIT,
  parameter int HANDLER_BASE   = intr_dispatcher_pkg::HANDLER_BASE,
  parameter int HANDLER_STRIDE = intr_dispatcher_pkg::HANDLER_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_raw,
  intr_dispatcher_if.master  bus
);

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  pending_q;
  logic [NUM_IRQ-1:0]  in_service_q;
  logic [NUM_IRQ-1:0]  higher_mask;
  logic [NUM_IRQ-1:0]  retire_oh;
  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  take_oh;
  logic [IRQ_ID_W-1:0] take_id;
  logic                take;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    intr_dispatcher_irq_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .irq_raw (irq_raw[i]),
      .rise    (rise[i])
    );
  end

  // Lines strictly above the active handler may nest; eret retires that handler
  always_comb begin : p_top
    logic seen;
    seen        = 1'b0;
    higher_mask = '0;
    retire_oh   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      retire_oh[i]   = in_service_q[i] & ~seen;
      higher_mask[i] = ~(seen | in_service_q[i]);
      seen           = seen | in_service_q[i];
    end
  end

  assign eligible = pending_q & bus.intr_mask & higher_mask;

  // Lowest index wins; id stays 0 when nothing is eligible
  always_comb begin
    take_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        take_id = IRQ_ID_W'(i);
      end
    end
  end

  // An eret retiring this cycle pushes any entry to the next cycle
  assign take    = bus.intr_en & (|eligible) & bus.take_ok & ~bus.is_eret;
  assign take_oh = take ? (NUM_IRQ'(1) << take_id) : '0;

  // Pending/in-service bookkeeping; a fresh edge beats the clear on the take edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      pending_q <= (pending_q & ~take_oh) | rise;
      if (take) begin
        in_service_q <= in_service_q | take_oh;
      end else if (bus.is_eret) begin
        in_service_q <= in_service_q & ~retire_oh;
      end
    end
  end

  assign bus.epc_w_en      = take;
  assign bus.redirect      = take;
  assign bus.epc_w_data    = take ? bus.pc_cur : '0;
  assign bus.irq_id        = take_id;
  assign bus.redirect_addr = ADDR_W'(HANDLER_BASE) + ADDR_W'(HANDLER_STRIDE) * ADDR_W'(take_id);
  assign bus.pending       = pending_q;
  assign bus.in_service    = in_service_q;

endmodule
